// File: rtl/fetch_predictor_pkg.sv
// rtl/fetch_predictor_pkg.sv - shared encodings and width helpers for the fetch predictor
package fetch_predictor_pkg;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_JAL    = 2'd2,
    CLS_JALR   = 2'd3
  } ctrl_class_e;

  typedef enum logic [1:0] {
    BTB_NOP    = 2'd0,
    BTB_UPDATE = 2'd1,
    BTB_ALLOC  = 2'd2,
    BTB_INVAL  = 2'd3
  } btb_op_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Freshly allocated entries start weakly taken.
  function automatic int ctr_init(input int bits);
    return 1 << (bits - 1);
  endfunction

  // A counter predicts taken when this bit is set.
  function automatic int ctr_taken_bit(input int bits);
    return bits - 1;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB, one combinational read port, one synchronous write port
module branch_target_buffer
  import fetch_predictor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int IDX      = clog2(ENTRIES),
  parameter int TAG_W    = XLEN - IDX - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX-1:0]      rd_idx_i,
  input  logic [TAG_W-1:0]    rd_tag_i,
  output logic                rd_hit_o,
  output logic [XLEN-1:0]     rd_target_o,
  output logic [CTR_BITS-1:0] rd_ctr_o,
  input  logic [IDX-1:0]      wr_idx_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  output logic                wr_hit_o,
  output logic [CTR_BITS-1:0] wr_ctr_o,
  input  btb_op_e             wr_op_i,
  input  logic [XLEN-1:0]     wr_target_i,
  input  logic                wr_target_en_i,
  input  logic [CTR_BITS-1:0] wr_ctr_i
);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = target_q[rd_idx_i];
  assign rd_ctr_o    = ctr_q[rd_idx_i];

  // Second probe on the EX side feeds the read-modify-write of the counter.
  assign wr_hit_o = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);
  assign wr_ctr_o = ctr_q[wr_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      case (wr_op_i)
        BTB_ALLOC: valid_q[wr_idx_i] <= 1'b1;
        BTB_INVAL: valid_q[wr_idx_i] <= 1'b0;
        default:   ;
      endcase
    end
  end

  // Payload arrays are left unreset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_op_i == BTB_ALLOC) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
      ctr_q[wr_idx_i]    <= wr_ctr_i;
    end else if (wr_op_i == BTB_UPDATE) begin
      ctr_q[wr_idx_i] <= wr_ctr_i;
      if (wr_target_en_i) target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/fetch_predictor.sv
// rtl/fetch_predictor.sv - fetch PC register with BTB-based next-PC prediction and EX redirect
module fetch_predictor
  import fetch_predictor_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter int              CTR_BITS    = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pred_next,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pred_next,
  output logic            id_flush,
  output logic            ex_flush
);

  localparam int                  IDX      = clog2(BTB_ENTRIES);
  localparam int                  TAG_W    = XLEN - IDX - 2;
  localparam int                  TK_BIT   = ctr_taken_bit(CTR_BITS);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

  logic [XLEN-1:0]     pc_q, pc_d;
  logic                rd_hit;
  logic [XLEN-1:0]     rd_target;
  logic [CTR_BITS-1:0] rd_ctr;
  logic                ex_hit;
  logic [CTR_BITS-1:0] ex_ctr;
  logic [CTR_BITS-1:0] ctr_nxt;
  logic [CTR_BITS-1:0] wr_ctr;
  ctrl_class_e         ex_cls;
  btb_op_e             btb_op;
  logic                actual_taken;
  logic [XLEN-1:0]     fixed_target;
  logic [XLEN-1:0]     correct_next;
  logic                mispredict;

  branch_target_buffer #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_btb (
    .clk            (clk),
    .rst            (rst),
    .rd_idx_i       (pc_q[IDX+1:2]),
    .rd_tag_i       (pc_q[XLEN-1:IDX+2]),
    .rd_hit_o       (rd_hit),
    .rd_target_o    (rd_target),
    .rd_ctr_o       (rd_ctr),
    .wr_idx_i       (ex_pc[IDX+1:2]),
    .wr_tag_i       (ex_pc[XLEN-1:IDX+2]),
    .wr_hit_o       (ex_hit),
    .wr_ctr_o       (ex_ctr),
    .wr_op_i        (btb_op),
    .wr_target_i    (fixed_target),
    .wr_target_en_i (actual_taken),
    .wr_ctr_i       (wr_ctr)
  );

  assign pc        = pc_q;
  assign pred_next = (rd_hit && rd_ctr[TK_BIT]) ? rd_target : pc_q + XLEN'(4);

  always_comb begin
    ex_cls = CLS_NONE;
    if (ex_is_jalr)        ex_cls = CLS_JALR;
    else if (ex_is_jal)    ex_cls = CLS_JAL;
    else if (ex_is_branch) ex_cls = CLS_BRANCH;
  end

  assign actual_taken = (ex_cls == CLS_JAL) || (ex_cls == CLS_JALR) ||
                        ((ex_cls == CLS_BRANCH) && ex_taken);
  assign fixed_target = (ex_cls == CLS_JALR) ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
  assign correct_next = actual_taken ? fixed_target : ex_pc + XLEN'(4);
  assign mispredict   = ex_valid && (ex_pred_next != correct_next);

  assign id_flush = mispredict && !rst;
  assign ex_flush = mispredict && !rst;

  always_comb begin
    ctr_nxt = ex_ctr;
    if (actual_taken) begin
      if (ex_ctr != '1) ctr_nxt = ex_ctr + CTR_BITS'(1);
    end else begin
      if (ex_ctr != '0) ctr_nxt = ex_ctr - CTR_BITS'(1);
    end
  end

  // A non-control instruction that hits is a tag alias and evicts the entry.
  always_comb begin
    btb_op = BTB_NOP;
    if (ex_valid && !rst) begin
      if (ex_cls != CLS_NONE) begin
        if (ex_hit)            btb_op = BTB_UPDATE;
        else if (actual_taken) btb_op = BTB_ALLOC;
      end else if (ex_hit) begin
        btb_op = BTB_INVAL;
      end
    end
  end

  assign wr_ctr = (btb_op == BTB_ALLOC) ? CTR_INIT : ctr_nxt;

  always_comb begin
    pc_d = pred_next;
    if (mispredict) pc_d = correct_next;
    else if (stall) pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule
